mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer/compare peripheral that answers the CPU's data-memory bus as a responder, beside the `memory` block. It decodes `funct3`-sized loads and stores in a 32-byte window. It provides a prescaled 32-bit up-counter with compare match, auto-reload, overflow detection and a level interrupt. Read data is registered with the same one-cycle latency as data memory, and is zero outside the window so the top level can OR it with memory read data.

## Interface
- `BASE_ADDR`, default 32'hFFFFFFE0: window base; must be 32-byte aligned.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `funct3`  in  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `dmem_wren`  in  1  store strobe for the current address.
- `dmem_address`  in  32  byte address.
- `dmem_data_in`  in  32  store data, right-aligned.
- `dmem_data_out`  out  32  load data, registered.
- `irq`  out  1  interrupt, registered level.

## Operation
- Hit: `dmem_address[31:5] == BASE_ADDR[31:5]`. Register index is `dmem_address[4:2]`. Lane is `dmem_address[1:0]`.
- Register map:
  - 0x00 CTRL[2:0]: bit0 EN, bit1 AUTORELOAD, bit2 IE. Upper bits read 0.
  - 0x04 COUNT, 32-bit, read/write.
  - 0x08 COMPARE, 32-bit, read/write.
  - 0x0C STATUS: bit0 MATCH, bit1 OVF. Write-1-to-clear.
  - 0x10 PRESCALE[15:0]. Upper bits read 0 and ignore writes.
  - 0x14–0x1C: read 0, writes ignored.
- Stores: sb writes lane `addr[1:0]` from `dmem_data_in[7:0]`. sh writes half `addr[1]` from `[15:0]`. sw writes all 32 bits. STATUS clears only the bits covered by the written lanes.
- Misaligned accesses are ignored and read 0. Misaligned means sh/lh/lhu with `addr[0]=1`, or sw/lw with `addr[1:0]!=0`. Undefined `funct3` is treated the same way.
- Loads: select the addressed byte or half and extend it. lb/lh sign-extend; lbu/lhu zero-extend.
- Prescaler: a 16-bit `pcnt` is held at 0 while EN=0.
  - While EN=1, `pcnt` increments each cycle.
  - When `pcnt==PRESCALE`, `pcnt` returns to 0 and `tick` pulses for one cycle.
  - COUNT therefore advances every PRESCALE+1 cycles.
- On `tick`:
  - If COUNT==COMPARE, set MATCH. COUNT becomes 0 if AUTORELOAD=1, otherwise COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - A 0xFFFFFFFF→0 increment sets OVF. A match reload does not set OVF.
- `irq` is the registered value of `IE & (MATCH | OVF)`.
- Simultaneous events:
  - A software write to COUNT in a tick cycle wins over the increment or reload. The match test still uses the old COUNT.
  - A W1C in the same cycle as a flag set leaves the flag set.
  - A write to PRESCALE takes effect for the next comparison. `pcnt` is not reset.
  - Writing EN=0 clears `pcnt` on the next edge.

## Timing
- Reset (asynchronous) sets all of these to 0: CTRL, COUNT, COMPARE, STATUS, PRESCALE, `pcnt`, `dmem_data_out`, `irq`.
- Read latency is 1 cycle. `dmem_data_out` captures, on edge N, the value addressed in cycle N-1. That value is taken from register contents before edge N's writes (read-old).
- A miss or misaligned access captures 0.
- A write at edge N is visible to a read presented in cycle N+1, with data on `dmem_data_out` at edge N+2.
- With PRESCALE=0 and EN set at edge N, the first tick is in cycle N+1, and COUNT=1 after edge N+2.
- MATCH is set at the same edge that applies the reload. `irq` rises one edge later.
- The bus has no wait states. Every access completes in one cycle.

## Test plan
- Reset mid-count: with COUNT=0x1234 running, assert `reset` between edges → all outputs 0 immediately, before the next edge. After release, COUNT reads 0.
- Free run: PRESCALE=3, CTRL=1. Read COUNT at intervals over 40 cycles → COUNT advances by 1 every 4 cycles.
- Auto-reload and interrupt:
  - Setup: PRESCALE=0, COMPARE=3, CTRL=7.
  - COUNT must cycle 0,1,2,3,0. MATCH=1, and `irq` rises one cycle after the reload edge.
  - An sw of 1 to 0x0C drops `irq` within 2 cycles.
- Overflow and W1C collision:
  - Set COUNT=0xFFFFFFFE, CTRL=5, PRESCALE=0 → OVF sets on the wrap.
  - A W1C in the same cycle as a new match leaves MATCH=1.
- Sized accesses:
  - sb 0xA5 to COMPARE+2 → COMPARE=0x00A50000.
  - lb at +2 reads 0xFFFFFFA5; lbu at +2 reads 0x000000A5; lh at +2 reads 0x000000A5.
  - lhu at +1 (misaligned) reads 0, and sw to 0x0E is ignored.
- Window decode:
  - A read of BASE_ADDR-4 returns 0.
  - A write to BASE_ADDR-4 leaves every register unchanged.
  - A write to COUNT in a tick cycle wins: written value 0x100 reads back as 0x100, not 0x101.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled timer/compare peripheral.
//
// Answers the data-memory bus as a responder in a 32-byte window at BASE_ADDR.
// Registers: CTRL (EN/AUTORELOAD/IE), COUNT, COMPARE, STATUS (MATCH/OVF, W1C),
// PRESCALE[15:0]. Load data is registered (one-cycle latency, read-old) and is
// zero outside the window so it can be OR-ed with memory read data.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   funct3        access size (b, h, w, bu, hu)
//   dmem_wren     store strobe
//   dmem_address  byte address
//   dmem_data_in  store data, right-aligned
//   dmem_data_out registered load data
//   irq           registered level interrupt
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFFE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        irq
);

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_COUNT    = 3'd1;
    localparam logic [2:0] IDX_COMPARE  = 3'd2;
    localparam logic [2:0] IDX_STATUS   = 3'd3;
    localparam logic [2:0] IDX_PRESCALE = 3'd4;

    logic [2:0]  ctrl;      // {IE, AUTORELOAD, EN}
    logic [31:0] count;
    logic [31:0] compare;
    logic [1:0]  status;    // {OVF, MATCH}
    logic [15:0] prescale;
    logic [15:0] pcnt;
    logic        tick;      // registered prescaler pulse, consumed the cycle after it is raised

    // ---------------- bus decode ----------------
    logic        hit, aligned, ok, wr;
    logic [2:0]  idx;
    logic [1:0]  lane;

    assign hit  = (dmem_address[31:5] == BASE_ADDR[31:5]);
    assign idx  = dmem_address[4:2];
    assign lane = dmem_address[1:0];

    always_comb begin
        aligned = 1'b0;
        case (funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~dmem_address[0];
            3'b010:         aligned = (dmem_address[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
    end

    assign ok = hit & aligned;
    assign wr = ok & dmem_wren;

    // Store data replicated across lanes; byte enables pick which lanes land.
    logic [3:0]  be;
    logic [31:0] wdata, wmask;

    always_comb begin
        be    = 4'b0000;
        wdata = dmem_data_in;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{dmem_data_in[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{dmem_data_in[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    // ---------------- read path ----------------
    logic [31:0] rd_reg, rd_shift, ld;

    always_comb begin
        rd_reg = 32'h0;
        case (idx)
            IDX_CTRL:     rd_reg = {29'h0, ctrl};
            IDX_COUNT:    rd_reg = count;
            IDX_COMPARE:  rd_reg = compare;
            IDX_STATUS:   rd_reg = {30'h0, status};
            IDX_PRESCALE: rd_reg = {16'h0, prescale};
            default:      rd_reg = 32'h0;
        endcase
    end

    assign rd_shift = rd_reg >> {lane, 3'b000};

    always_comb begin
        ld = 32'h0;
        case (funct3)
            3'b000:  ld = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld = {24'h0, rd_shift[7:0]};
            3'b001:  ld = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld = {16'h0, rd_shift[15:0]};
            3'b010:  ld = rd_reg;
            default: ld = 32'h0;
        endcase
    end

    // ---------------- timer next state ----------------
    logic        is_match, reload, set_match, set_ovf;
    logic [31:0] count_nx;
    logic [2:0]  ctrl_nx;
    logic [31:0] compare_nx;
    logic [1:0]  status_nx, status_clr;
    logic [15:0] prescale_nx, pcnt_nx;
    logic        tick_nx;

    always_comb begin
        is_match  = (count == compare);
        reload    = tick & is_match & ctrl[1];
        set_match = tick & is_match;
        // A reload never counts as overflow; only a real 0xFFFFFFFF+1 does.
        set_ovf   = tick & ~reload & (count == 32'hFFFF_FFFF);

        count_nx = count;
        if (tick)
            count_nx = reload ? 32'h0 : count + 32'd1;
        // Software write wins over increment/reload; the match test above
        // already used the old COUNT.
        if (wr && idx == IDX_COUNT)
            count_nx = (count & ~wmask) | (wdata & wmask);

        compare_nx = compare;
        if (wr && idx == IDX_COMPARE)
            compare_nx = (compare & ~wmask) | (wdata & wmask);

        ctrl_nx = ctrl;
        if (wr && idx == IDX_CTRL && be[0])
            ctrl_nx = wdata[2:0];

        prescale_nx = prescale;
        if (wr && idx == IDX_PRESCALE) begin
            if (be[0]) prescale_nx[7:0]  = wdata[7:0];
            if (be[1]) prescale_nx[15:8] = wdata[15:8];
        end

        status_clr = 2'b00;
        if (wr && idx == IDX_STATUS && be[0])
            status_clr = wdata[1:0];
        // Setting beats clearing when both land on the same edge.
        status_nx = (status & ~status_clr) | {set_ovf, set_match};

        tick_nx = ctrl[0] & (pcnt == prescale);
        if (!ctrl[0])
            pcnt_nx = 16'h0;
        else if (pcnt == prescale)
            pcnt_nx = 16'h0;
        else
            pcnt_nx = pcnt + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl          <= '0;
            count         <= '0;
            compare       <= '0;
            status        <= '0;
            prescale      <= '0;
            pcnt          <= '0;
            tick          <= 1'b0;
            dmem_data_out <= '0;
            irq           <= 1'b0;
        end else begin
            ctrl          <= ctrl_nx;
            count         <= count_nx;
            compare       <= compare_nx;
            status        <= status_nx;
            prescale      <= prescale_nx;
            pcnt          <= pcnt_nx;
            tick          <= tick_nx;
            dmem_data_out <= ok ? ld : 32'h0;
            irq           <= ctrl[2] & (|status);
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed literal checks plus randomized traffic, compared
// every cycle against a behavioural model of the timer peripheral.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFFFFE0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  funct3 = 3'b010;
    logic        dmem_wren = 1'b0;
    logic [31:0] dmem_address = 32'h0;
    logic [31:0] dmem_data_in = 32'h0;
    logic [31:0] dmem_data_out;
    logic        irq;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .funct3(funct3), .dmem_wren(dmem_wren),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_data_out(dmem_data_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_ctrl, m_count, m_cmp, m_stat, m_pre, m_pcnt, m_dout;
    bit          m_tick, m_irq;

    function automatic logic [31:0] m_reg(input int i);
        case (i)
            0:       return m_ctrl;
            1:       return m_count;
            2:       return m_cmp;
            3:       return m_stat;
            4:       return m_pre;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        int          size, lane, idx;
        bit          ok, tick_now;
        logic [31:0] v, nc, ncmp, nctrl, npre, set, clr;
        logic [7:0]  by;
        idx  = int'(dmem_address[4:2]);
        lane = int'(dmem_address[1:0]);
        case (funct3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        ok = (dmem_address[31:5] == BASE[31:5]) && size != 0 && (lane % size) == 0;

        v = m_reg(idx) >> (8 * lane);
        if (size == 1) begin
            v = v % 256;
            if (funct3 == 3'd0 && v >= 128) v = v - 256;
        end else if (size == 2) begin
            v = v % 65536;
            if (funct3 == 3'd1 && v >= 32768) v = v - 65536;
        end

        tick_now = m_tick;
        set = 0;
        nc  = m_count;
        if (tick_now) begin
            if (m_count == m_cmp) set = 1;
            if (m_count == m_cmp && m_ctrl[1]) nc = 0;
            else begin
                nc = m_count + 1;
                if (nc == 0) set = set | 2;
            end
        end

        clr = 0; ncmp = m_cmp; nctrl = m_ctrl; npre = m_pre;
        if (ok && dmem_wren) begin
            for (int b = lane; b < lane + size; b++) begin
                by = dmem_data_in[8*(b-lane) +: 8];
                case (idx)
                    0: nctrl[8*b +: 8] = by;
                    1: begin
                        if (b == lane) nc = m_count;
                        nc[8*b +: 8] = by;
                    end
                    2: ncmp[8*b +: 8] = by;
                    3: if (b == 0) clr = by & 3;
                    4: npre[8*b +: 8] = by;
                    default: ;
                endcase
            end
        end

        m_dout = ok ? v : 32'h0;
        m_irq  = m_ctrl[2] && m_stat != 0;
        m_tick = m_ctrl[0] && m_pcnt == m_pre;
        m_pcnt = (m_ctrl[0] && m_pcnt != m_pre) ? m_pcnt + 1 : 0;
        m_count = nc;
        m_cmp   = ncmp;
        m_ctrl  = nctrl & 7;
        m_pre   = npre & 32'hFFFF;
        m_stat  = (m_stat & ~clr) | set;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl = 0; m_count = 0; m_cmp = 0; m_stat = 0; m_pre = 0;
            m_pcnt = 0; m_dout = 0; m_tick = 0; m_irq = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            tests++;
            if (dmem_data_out !== m_dout || irq !== m_irq) begin
                fails++;
                $display("FAIL model_cmp t=%0t dout=%h irq=%b want dout=%h irq=%b",
                         $time, dmem_data_out, irq, m_dout, m_irq);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // One bus access; returns 1 time unit after the edge that captured it.
    task automatic acc(input logic [2:0] f, input bit we, input logic [31:0] a, input logic [31:0] d);
        funct3 = f; dmem_wren = we; dmem_address = a; dmem_data_in = d;
        @(posedge clk); #1;
        dmem_wren = 1'b0; dmem_address = 32'h0; funct3 = 3'b010;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        acc(3'b010, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] f, input logic [31:0] a, output logic [31:0] v);
        acc(f, 1'b0, a, 32'h0);
        v = dmem_data_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) acc(3'b010, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1; #2; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v, c0, c1;
        logic [31:0] expseq [7];
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_dout", dmem_data_out, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        // Reset mid-count
        wr(BASE + 8, 32'h1234);
        wr(BASE + 4, 32'h1234);
        wr(BASE + 0, 32'h5);
        idle(4);
        rd(3'b010, BASE + 4, v);
        chk("midcount_count", v, 32'h1237);
        chk("midcount_irq", {31'h0, irq}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_dout", dmem_data_out, 32'h0);
        chk("async_reset_irq", {31'h0, irq}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        rd(3'b010, BASE + 4, v);
        chk("post_reset_count", v, 32'h0);

        // First-tick latency and free run with PRESCALE=3
        wr(BASE + 0, 32'h1);
        rd(3'b010, BASE + 4, v); chk("lat_rd0", v, 32'h0);
        rd(3'b010, BASE + 4, v); chk("lat_rd1", v, 32'h0);
        rd(3'b010, BASE + 4, v); chk("lat_rd2", v, 32'h1);
        do_reset();
        wr(BASE + 16, 32'h3);
        wr(BASE + 0, 32'h1);
        idle(2);
        rd(3'b010, BASE + 4, c0);
        for (int i = 0; i < 9; i++) begin
            idle(3);
            rd(3'b010, BASE + 4, c1);
            chk("freerun_step", c1 - c0, 32'h1);
            c0 = c1;
        end

        // Auto-reload and interrupt
        do_reset();
        wr(BASE + 8, 32'h3);
        wr(BASE + 0, 32'h7);
        expseq = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h1};
        for (int i = 0; i < 7; i++) begin
            rd(3'b010, BASE + 4, v);
            chk("reload_seq", v, expseq[i]);
        end
        chk("reload_irq", {31'h0, irq}, 32'h1);
        rd(3'b010, BASE + 12, v);
        chk("reload_status", v, 32'h1);
        wr(BASE + 0, 32'h6);
        idle(3);
        wr(BASE + 12, 32'h1);
        for (int n = 0; n < 2 && irq; n++) idle(1);
        chk("w1c_irq_drop", {31'h0, irq}, 32'h0);

        // Overflow
        do_reset();
        wr(BASE + 8, 32'h5);
        wr(BASE + 4, 32'hFFFF_FFFE);
        wr(BASE + 0, 32'h5);
        rd(3'b010, BASE + 4, v); chk("ovf_c0", v, 32'hFFFF_FFFE);
        rd(3'b010, BASE + 4, v); chk("ovf_c1", v, 32'hFFFF_FFFE);
        rd(3'b010, BASE + 4, v); chk("ovf_c2", v, 32'hFFFF_FFFF);
        rd(3'b010, BASE + 4, v); chk("ovf_c3", v, 32'h0);
        rd(3'b010, BASE + 12, v); chk("ovf_status", v, 32'h2);
        chk("ovf_irq", {31'h0, irq}, 32'h1);

        // W1C colliding with a new match
        do_reset();
        wr(BASE + 8, 32'h2);
        wr(BASE + 0, 32'h1);
        idle(3);
        wr(BASE + 12, 32'h3);
        rd(3'b010, BASE + 12, v);
        chk("w1c_collision", v, 32'h1);

        // Sized accesses
        do_reset();
        acc(3'b000, 1'b1, BASE + 32'hA, 32'hFFFF_FFA5);
        rd(3'b010, BASE + 8,  v); chk("sb_compare", v, 32'h00A5_0000);
        rd(3'b000, BASE + 10, v); chk("lb", v, 32'hFFFF_FFA5);
        rd(3'b100, BASE + 10, v); chk("lbu", v, 32'h0000_00A5);
        rd(3'b001, BASE + 10, v); chk("lh_pos", v, 32'h0000_00A5);
        rd(3'b101, BASE + 9,  v); chk("lhu_misaligned", v, 32'h0);
        acc(3'b010, 1'b1, BASE + 32'hE, 32'hDEAD_BEEF);
        rd(3'b010, BASE + 8,  v); chk("sw_misaligned_ignored", v, 32'h00A5_0000);
        acc(3'b000, 1'b1, BASE + 32'hB, 32'h80);
        rd(3'b001, BASE + 10, v); chk("lh_neg", v, 32'hFFFF_80A5);
        rd(3'b101, BASE + 10, v); chk("lhu", v, 32'h0000_80A5);
        rd(3'b011, BASE + 8,  v); chk("undef_funct3", v, 32'h0);

        // Window decode and reserved/upper bits
        wr(BASE - 4, 32'h55);
        rd(3'b010, BASE - 4, v); chk("below_window", v, 32'h0);
        rd(3'b010, BASE + 8, v); chk("outside_write_cmp", v, 32'h80A5_0000);
        rd(3'b010, BASE + 4, v); chk("outside_write_cnt", v, 32'h0);
        wr(BASE + 16, 32'hFFFF_FFFF);
        rd(3'b010, BASE + 16, v); chk("prescale_upper", v, 32'h0000_FFFF);
        wr(BASE + 16, 32'h0);
        wr(BASE + 20, 32'hFFFF_FFFF);
        rd(3'b010, BASE + 20, v); chk("reserved_reg", v, 32'h0);

        // Software COUNT write wins over a concurrent tick
        wr(BASE + 0, 32'h1);
        idle(2);
        wr(BASE + 4, 32'h100);
        rd(3'b010, BASE + 4, v); chk("count_write_wins", v, 32'h100);
        rd(3'b010, BASE + 4, v); chk("count_after_write", v, 32'h101);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, d;
            logic [2:0]  f;
            bit          we;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE - $urandom_range(1, 8);
                default: a = BASE + $urandom_range(0, 31);
            endcase
            f  = 3'($urandom_range(0, 7));
            we = ($urandom_range(0, 2) == 0);
            case (a[4:2])
                3'd1: case ($urandom_range(0, 2))
                          0:       d = $urandom;
                          1:       d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                          default: d = $urandom_range(0, 15);
                      endcase
                3'd2: d = $urandom_range(0, 15);
                3'd4: d = $urandom_range(0, 3);
                default: d = $urandom;
            endcase
            acc(f, we, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
